// File: rtl/lianliankan_pkg.sv
// Shared definitions for the card-matching game logic: judge FSM state
// encodings, default tile-type width and a tile-type lookup helper.
package lianliankan_pkg;

   localparam int TYPE_W_DEF  = 3;
   localparam int TYPES_MAX_W = 256;
   localparam int TYPE_MAX_W  = 8;

   localparam logic [4:0] S_IDLE    = 5'b00001;
   localparam logic [4:0] S_COMPARE = 5'b00010;
   localparam logic [4:0] S_RESULT  = 5'b00100;
   localparam logic [4:0] S_COOL    = 5'b01000;
   localparam logic [4:0] S_DONE    = 5'b10000;

   typedef enum logic [4:0] {
      ST_IDLE    = S_IDLE,
      ST_COMPARE = S_COMPARE,
      ST_RESULT  = S_RESULT,
      ST_COOL    = S_COOL,
      ST_DONE    = S_DONE
   } judge_state_t;

   // Callers zero-extend their packed type vector to TYPES_MAX_W bits.
   function automatic logic [TYPE_MAX_W-1:0] card_type_at(
      input logic [TYPES_MAX_W-1:0] types,
      input int unsigned            idx,
      input int unsigned            tw
   );
      logic [TYPES_MAX_W-1:0] shifted;
      logic [TYPE_MAX_W-1:0]  mask;
      shifted = types >> (idx * tw);
      mask    = (TYPE_MAX_W'(1) << tw) - TYPE_MAX_W'(1);
      return shifted[TYPE_MAX_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/sel_pair_encoder.sv
// Combinational encoder: counts selected cards (saturating at 3) and reports
// the lowest and second-lowest selected indices.
module sel_pair_encoder #(
   parameter int N_CARDS = 16
) (
   input  logic [N_CARDS-1:0]         i_v,
   output logic [1:0]                 o_cnt,
   output logic [$clog2(N_CARDS)-1:0] o_ia,
   output logic [$clog2(N_CARDS)-1:0] o_ib
);

   localparam int IW = $clog2(N_CARDS);

   logic w_found_a;
   logic w_found_b;

   always_comb begin
      o_cnt     = 2'd0;
      o_ia      = '0;
      o_ib      = '0;
      w_found_a = 1'b0;
      w_found_b = 1'b0;
      for (int i = 0; i < N_CARDS; i++) begin
         if (i_v[i]) begin
            if (!w_found_a) begin
               o_ia      = IW'(i);
               w_found_a = 1'b1;
            end else if (!w_found_b) begin
               o_ib      = IW'(i);
               w_found_b = 1'b1;
            end
            if (o_cnt != 2'd3) o_cnt = o_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/match_judge.sv
// Match arbiter: judges two selected cards, pulses ms/mf back to them,
// and tracks remaining pairs and the sticky win flag.
module match_judge
   import lianliankan_pkg::*;
#(
   parameter int N_CARDS     = 16,
   parameter int TYPE_W      = TYPE_W_DEF,
   parameter int COOL_CYCLES = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [N_CARDS-1:0]                  sel,
   input  logic [N_CARDS-1:0]                  hidden,
   input  logic [N_CARDS*TYPE_W-1:0]           types,
   output logic [N_CARDS-1:0]                  mf,
   output logic [N_CARDS-1:0]                  ms,
   output logic [$clog2(N_CARDS/2+1)-1:0]      pairs_left,
   output logic                                won,
   output logic                                busy,
   output logic [4:0]                          dbg_state
);

   localparam int IW = $clog2(N_CARDS);
   localparam int PW = $clog2(N_CARDS/2+1);
   localparam int CW = $clog2(COOL_CYCLES+1);
   localparam logic [PW-1:0]      PAIRS_INIT = PW'(N_CARDS/2);
   localparam logic [CW-1:0]      COOL_LOAD  = CW'(COOL_CYCLES-1);
   localparam logic [N_CARDS-1:0] ONE        = N_CARDS'(1);

   judge_state_t       r_state;
   logic [IW-1:0]      r_a;
   logic [IW-1:0]      r_b;
   logic [N_CARDS-1:0] r_mask;
   logic               r_ovf;
   logic               r_eq;
   logic [CW-1:0]      r_cool;
   logic [PW-1:0]      r_pairs;
   logic [N_CARDS-1:0] r_ms;
   logic [N_CARDS-1:0] r_mf;
   logic               r_won;

   logic [N_CARDS-1:0]     w_v;
   logic [1:0]             w_cnt;
   logic [IW-1:0]          w_ia;
   logic [IW-1:0]          w_ib;
   logic [TYPES_MAX_W-1:0] w_types_ext;
   logic [TYPE_MAX_W-1:0]  w_type_a;
   logic [TYPE_MAX_W-1:0]  w_type_b;

   // Cards already removed from the board never count as selected.
   assign w_v = sel & ~hidden;

   sel_pair_encoder #(.N_CARDS(N_CARDS)) u_enc (
      .i_v   (w_v),
      .o_cnt (w_cnt),
      .o_ia  (w_ia),
      .o_ib  (w_ib)
   );

   assign w_types_ext = TYPES_MAX_W'(types);
   assign w_type_a    = card_type_at(w_types_ext, 32'(r_a), 32'(TYPE_W));
   assign w_type_b    = card_type_at(w_types_ext, 32'(r_b), 32'(TYPE_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_mask  <= '0;
         r_ovf   <= 1'b0;
         r_eq    <= 1'b0;
         r_cool  <= '0;
         r_pairs <= PAIRS_INIT;
         r_ms    <= '0;
         r_mf    <= '0;
         r_won   <= 1'b0;
      end else begin
         r_ms <= '0;
         r_mf <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_cnt == 2'd2) begin
                  r_a     <= w_ia;
                  r_b     <= w_ib;
                  r_ovf   <= 1'b0;
                  r_state <= ST_COMPARE;
               end else if (w_cnt == 2'd3) begin
                  r_mask  <= w_v;
                  r_ovf   <= 1'b1;
                  r_state <= ST_RESULT;
               end
            end
            ST_COMPARE: begin
               r_eq    <= (w_type_a == w_type_b);
               r_state <= ST_RESULT;
            end
            ST_RESULT: begin
               if (!r_ovf && r_eq) begin
                  // A match with no pairs left is impossible in a sane game; park in DONE.
                  if (r_pairs == '0) begin
                     r_won   <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_ms    <= (ONE << r_a) | (ONE << r_b);
                     r_pairs <= r_pairs - PW'(1);
                     r_cool  <= COOL_LOAD;
                     r_state <= ST_COOL;
                  end
               end else begin
                  r_mf    <= r_ovf ? r_mask : ((ONE << r_a) | (ONE << r_b));
                  r_cool  <= COOL_LOAD;
                  r_state <= ST_COOL;
               end
            end
            ST_COOL: begin
               // Lets the cards drop sel before the next sample.
               if (r_cool == '0) begin
                  if (r_pairs == '0) begin
                     r_won   <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cool <= r_cool - CW'(1);
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ms         = r_ms;
   assign mf         = r_mf;
   assign pairs_left = r_pairs;
   assign won        = r_won;
   assign busy       = (r_state != ST_IDLE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: vector table of card selections plus hand-written
// sequences for frozen judgement, mid-judgement reset and a complete game.
module tb_match_judge;

   localparam int N  = 16;
   localparam int TW = 3;
   localparam int PW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    sel;
   logic [N-1:0]    hidden;
   logic [N*TW-1:0] types;
   logic [N-1:0]    mf;
   logic [N-1:0]    ms;
   logic [PW-1:0]   pairs_left;
   logic            won;
   logic            busy;
   logic [4:0]      dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] exp_e;
   int tarr[N];

   typedef struct {
      logic [N-1:0]  sel;
      logic [N-1:0]  exp_ms;
      logic [N-1:0]  exp_mf;
      logic [PW-1:0] exp_pl;
   } vec_t;
   vec_t vecs[11];

   match_judge #(.N_CARDS(N), .TYPE_W(TW), .COOL_CYCLES(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (sel),
      .hidden     (hidden),
      .types      (types),
      .mf         (mf),
      .ms         (ms),
      .pairs_left (pairs_left),
      .won        (won),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out", name);
   endtask

   // scoreboard: every result pulse must match the head of exp_q
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (ms | mf) != '0) begin
         if ((ms & mf) != '0) check("ms_mf_overlap", 32'(ms & mf), 32'h0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {ms, mf}, 32'h0);
         end else begin
            exp_e = exp_q.pop_front();
            check("pulse", {ms, mf}, exp_e);
         end
      end
   end

   // driver tasks
   task automatic load_types();
      logic [N*TW-1:0] t;
      logic [31:0] tv;
      t = '0;
      for (int i = 0; i < N; i++) begin
         tv = tarr[i];
         t[i*TW +: TW] = tv[TW-1:0];
      end
      types = t;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) fail_timeout(name);
   endtask

   task automatic wait_settled(input string name);
      int k;
      k = 0;
      while (busy !== 1'b0 && dbg_state !== 5'b10000 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) fail_timeout(name);
   endtask

   task automatic judge(input logic [N-1:0] s, input logic [N-1:0] e_ms,
                        input logic [N-1:0] e_mf, input logic [PW-1:0] e_pl,
                        input string name);
      int lat;
      int exp_lat;
      wait_idle({name, "_ready"});
      @(negedge clk);
      sel = s;
      exp_lat = ($countones(s & ~hidden) >= 3) ? 2 : 3;
      exp_q.push_back({e_ms, e_mf});
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while ((ms | mf) == '0 && lat < 20);
      if (lat >= 20) begin
         fail_timeout({name, "_pulse"});
         void'(exp_q.pop_back());
      end else begin
         check({name, "_latency"}, 32'(lat), 32'(exp_lat));
         check({name, "_busy"}, 32'(busy), 32'h1);
         check({name, "_pairs"}, 32'(pairs_left), 32'(e_pl));
      end
      sel = '0;
      hidden = hidden | e_ms;
      wait_settled({name, "_settle"});
   endtask

   initial begin
      int bad;
      rst_n  = 1'b0;
      sel    = '0;
      hidden = '0;
      tarr   = '{1, 2, 0, 5, 3, 3, 6, 7, 4, 5, 0, 1, 2, 6, 7, 4};
      load_types();

      vecs[0]  = '{16'h0208, 16'h0208, 16'h0000, 4'd7};
      vecs[1]  = '{16'h0003, 16'h0000, 16'h0003, 4'd7};
      vecs[2]  = '{16'h0007, 16'h0000, 16'h0007, 4'd7};
      vecs[3]  = '{16'h0030, 16'h0030, 16'h0000, 4'd6};
      vecs[4]  = '{16'h0409, 16'h0000, 16'h0401, 4'd6};
      vecs[5]  = '{16'h8100, 16'h8100, 16'h0000, 4'd5};
      vecs[6]  = '{16'h0840, 16'h0000, 16'h0840, 4'd5};
      vecs[7]  = '{16'h2040, 16'h2040, 16'h0000, 4'd4};
      vecs[8]  = '{16'h0C00, 16'h0000, 16'h0C00, 4'd4};
      vecs[9]  = '{16'h003B, 16'h0000, 16'h0003, 4'd4};
      vecs[10] = '{16'hC807, 16'h0000, 16'h4807, 4'd4};

      repeat (3) @(negedge clk);
      check("reset_pairs", 32'(pairs_left), 32'd8);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_won", 32'(won), 32'h0);
      check("reset_state", 32'(dbg_state), 32'h1);
      rst_n = 1'b1;

      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pairs_left !== 4'd8 || busy !== 1'b0 || ms !== '0 || mf !== '0) bad++;
      end
      check("idle_quiet", 32'(bad), 32'h0);

      for (int i = 0; i < 11; i++)
         judge(vecs[i].sel, vecs[i].exp_ms, vecs[i].exp_mf, vecs[i].exp_pl, $sformatf("vec%0d", i));

      // sel changes during COMPARE must not alter the frozen pair (2,10)
      wait_idle("frozen_ready");
      @(negedge clk);
      sel = 16'h0404;
      exp_q.push_back({16'h0404, 16'h0000});
      @(negedge clk);
      check("frozen_compare_state", 32'(dbg_state), 32'h2);
      sel = 16'h0003;
      @(negedge clk);
      @(negedge clk);
      check("frozen_pairs", 32'(pairs_left), 32'd3);
      sel = '0;
      hidden = hidden | 16'h0404;
      wait_idle("frozen_settle");
      repeat (5) @(negedge clk);
      check("frozen_queue", 32'(exp_q.size()), 32'h0);

      // reset one cycle after the pair is sampled
      hidden = '0;
      @(negedge clk);
      sel = 16'h0208;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_pairs", 32'(pairs_left), 32'd8);
      check("midrst_pulse", {ms, mf}, 32'h0);
      sel = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("midrst_pairs_after", 32'(pairs_left), 32'd8);
      check("midrst_state_after", 32'(dbg_state), 32'h1);

      // complete game: card 2k pairs with card 2k+1
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) tarr[i] = i / 2;
      load_types();
      hidden = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++)
         judge(16'h0003 << (2 * k), 16'h0003 << (2 * k), 16'h0000, PW'(7 - k),
               $sformatf("game%0d", k));
      check("game_won", 32'(won), 32'h1);
      check("game_done_state", 32'(dbg_state), 32'h10);
      check("game_pairs", 32'(pairs_left), 32'h0);
      hidden = '0;
      sel = 16'h0003;
      repeat (20) @(negedge clk);
      sel = 16'h0007;
      repeat (10) @(negedge clk);
      sel = '0;
      check("game_won_sticky", 32'(won), 32'h1);
      check("game_busy_done", 32'(busy), 32'h1);
      check("final_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/match_judge.md
# match_judge

Game-logic arbiter that closes the loop with the per-card state machines: it watches every card's `sel` and `hidden` outputs, and when exactly two cards are selected it compares their tile types. It then returns a one-cycle `ms` (match success) or `mf` (match failure) pulse to those two cards only. It sits between the card array and the display/top level, and also tracks remaining pairs and the win condition.

## Interface
- `N_CARDS`, 16 — number of cards; must be even, ≥ 4.
- `TYPE_W`, 3 — width of one card's tile-type code.
- `COOL_CYCLES`, 3 — cycles to ignore `sel` after a result pulse; must be ≥ 3 to cover card state plus output register latency.
- `clk` input 1 — system clock, rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `sel` input N_CARDS — per-card selected flag from the card instances.
- `hidden` input N_CARDS — per-card matched/removed flag.
- `types` input N_CARDS*TYPE_W — packed tile types; card i occupies bits [i*TYPE_W +: TYPE_W]; static during a game.
- `mf` output N_CARDS — per-card match-failure pulse.
- `ms` output N_CARDS — per-card match-success pulse.
- `pairs_left` output $clog2(N_CARDS/2+1) — unmatched pairs remaining.
- `won` output 1 — all pairs matched; sticky until reset.
- `busy` output 1 — high in any state other than IDLE.

## Operation
- Effective selection: `v = sel & ~hidden`.
- The combinational encoder produces:
  - `cnt`, saturating at 3;
  - `ia`, the lowest set index of `v`;
  - `ib`, the next set index of `v`.
- FSM states: IDLE, COMPARE, RESULT, COOL, DONE. Encode as one-hot.
- IDLE:
  - `cnt` 0 or 1: stay in IDLE.
  - `cnt` == 2: register `ia`, `ib` into `a`, `b`; go to COMPARE.
  - `cnt` ≥ 3: register the mask `v`, flag it as overflow, go to RESULT. Overflow forces a failure for all cards in the mask.
- COMPARE: register `eq = (type[a] == type[b])`, then go to RESULT.
- RESULT:
  - Match (`eq`): drive `ms` one-hot at bits `a` and `b`; decrement `pairs_left`.
  - No match or overflow: drive `mf` at `a`/`b`, or at every bit of the overflow mask.
  - Then load the cool counter with COOL_CYCLES−1 and go to COOL.
- COOL:
  - Count down and ignore `sel`.
  - At 0: go to DONE if `pairs_left` == 0, else go to IDLE.
- DONE: absorbing state; `won` = 1; `mf`/`ms` held at 0.
- `ms` and `mf` are never both set for the same card in the same cycle.
- At most one result pulse is issued per judgement.
- `pairs_left` never underflows. If a decrement would take it below 0, it is held at 0 and the FSM goes to DONE.

## Timing
- Reset values: `mf`=0, `ms`=0, `pairs_left`=N_CARDS/2, `won`=0, `busy`=0, FSM in IDLE, `a`=`b`=0.
- Latency:
  - `sel` pair first sampled in IDLE at edge t.
  - COMPARE at t+1.
  - `mf`/`ms` are registered outputs, high for exactly the one cycle following edge t+2.
- `pairs_left` updates on the same edge that raises `ms`.
- `won` rises on the edge entering DONE.
- `busy` rises at edge t and falls on the edge returning to IDLE.
- `sel` changes during COMPARE or RESULT do not alter the judgement in progress; the indices and mask are frozen at edge t.
- A card deselected during COOL is re-evaluated only once the FSM is back in IDLE.
- Reset asserted mid-judgement: all outputs go to their reset values immediately (asynchronously); no pulse leaks after release.
- A `hidden` bit rising on a card while the FSM is in IDLE removes that card from `v` in the same cycle.

## Structure
- Shared package `lianliankan_pkg` holds:
  - the FSM state localparams (one-hot);
  - the TYPE_W default;
  - a `card_type_at(types, idx)` function.
- Sub-module `sel_pair_encoder`: purely combinational; turns `v` into `cnt`, `ia` and `ib`.
- `match_judge` holds the FSM, the cool counter, the `pairs_left` register and the output registers.

## Test plan
- Reset, then no `sel` → `pairs_left`=8, `busy`=0, `mf`=`ms`=0 for 20 cycles (N_CARDS=16).
- types[3]=types[9]=5; `sel` = 1<<3 | 1<<9 → `ms`=0x0208 for exactly 1 cycle, 3 cycles after the sample edge; `pairs_left` 8→7; `mf` stays 0.
- types[0]=1, types[1]=2; `sel`=0x0003 → `mf`=0x0003 for 1 cycle; `pairs_left` unchanged; `sel` dropping during COOL triggers no second pulse.
- `sel`=0x0007 (three cards) → `mf`=0x0007 for 1 cycle, no `ms`.
- Play 8 matching pairs sequentially → `pairs_left` reaches 0, `won`=1 and stays 1; later `sel` activity produces no pulses.
- Assert `rst_n`=0 one cycle after a pair is sampled → no `ms`/`mf` pulse appears; `pairs_left`=8 after release.
